// File: rtl/eth_dds_cfg_mc.sv
// UDP packet decoder that stages DDS register writes in a shadow set and commits them per channel.
// Optional macro CFG_STATUS_EN adds saturating good/bad packet counters.
module eth_dds_cfg_mc #(
    parameter int unsigned NUM_CH = 2,
    parameter logic [15:0] MAGIC  = 16'h5AA5
) (
    input  logic                     eth_rx_clk,
    input  logic                     sys_rst,
    input  logic                     rec_en,
    input  logic [31:0]              rec_data,
    input  logic                     rec_pkt_done,
    input  logic [15:0]              rec_byte_num,
    output logic [4*NUM_CH-1:0]      wave_select,
    output logic [9*NUM_CH-1:0]      amp_ctl,
    output logic [32*NUM_CH-1:0]     freq_ctl,
    output logic [32*NUM_CH-1:0]     min_ctl,
    output logic [12*NUM_CH-1:0]     phase_ctl,
    output logic [NUM_CH-1:0]        cfg_update,
`ifdef CFG_STATUS_EN
    output logic [15:0]              pkt_ok_cnt,
    output logic [15:0]              pkt_err_cnt,
`endif
    output logic                     pkt_err
);

    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0]  RST_WAVE  = 4'd0;
    localparam logic [8:0]  RST_AMP   = 9'd256;
    localparam logic [31:0] RST_FREQ  = 32'd3615292;
    localparam logic [31:0] RST_MIN   = 32'd0;
    localparam logic [11:0] RST_PHASE = 12'd1024;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_END  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [7:0]        r_nreg;
    logic [7:0]        r_cnt;
    logic [2:0]        r_addr;
    logic [3:0]        r_sh_wave;
    logic [8:0]        r_sh_amp;
    logic [31:0]       r_sh_freq;
    logic [31:0]       r_sh_min;
    logic [11:0]       r_sh_phase;

    state_t            w_state;
    logic [CH_W-1:0]   w_ch;
    logic [7:0]        w_nreg;
    logic [7:0]        w_cnt;
    logic [2:0]        w_addr;
    logic [3:0]        w_sh_wave;
    logic [8:0]        w_sh_amp;
    logic [31:0]       w_sh_freq;
    logic [31:0]       w_sh_min;
    logic [11:0]       w_sh_phase;
    logic [15:0]       w_exp_bytes;
    logic              w_commit;

    // Effect of this cycle's word; the end-of-packet decision looks at this result.
    always_comb begin
        w_state    = r_state;
        w_ch       = r_ch;
        w_nreg     = r_nreg;
        w_cnt      = r_cnt;
        w_addr     = r_addr;
        w_sh_wave  = r_sh_wave;
        w_sh_amp   = r_sh_amp;
        w_sh_freq  = r_sh_freq;
        w_sh_min   = r_sh_min;
        w_sh_phase = r_sh_phase;
        if (rec_en) begin
            case (r_state)
                S_HDR: begin
                    if (rec_data[31:16] == MAGIC && rec_data[15:8] < 8'(NUM_CH)
                        && rec_data[7:0] != 8'd0) begin
                        w_ch    = CH_W'(rec_data[15:8]);
                        w_nreg  = rec_data[7:0];
                        w_cnt   = rec_data[7:0];
                        w_state = S_ADDR;
                        for (int unsigned n = 0; n < NUM_CH; n++) begin
                            if (rec_data[15:8] == 8'(n)) begin
                                w_sh_wave  = wave_select[4*n +: 4];
                                w_sh_amp   = amp_ctl[9*n +: 9];
                                w_sh_freq  = freq_ctl[32*n +: 32];
                                w_sh_min   = min_ctl[32*n +: 32];
                                w_sh_phase = phase_ctl[12*n +: 12];
                            end
                        end
                    end else begin
                        w_state = S_ERR;
                    end
                end
                S_ADDR: begin
                    if (rec_data[3:0] <= 4'd4) begin
                        w_addr  = rec_data[2:0];
                        w_state = S_DATA;
                    end else begin
                        w_state = S_ERR;
                    end
                end
                S_DATA: begin
                    case (r_addr)
                        3'd0:    w_sh_wave  = rec_data[3:0];
                        3'd1:    w_sh_amp   = rec_data[8:0];
                        3'd2:    w_sh_freq  = rec_data;
                        3'd3:    w_sh_min   = rec_data;
                        default: w_sh_phase = rec_data[11:0];
                    endcase
                    w_cnt   = r_cnt - 8'd1;
                    w_state = (r_cnt == 8'd1) ? S_END : S_ADDR;
                end
                S_END:   w_state = S_ERR;
                default: w_state = S_ERR;
            endcase
        end
    end

    assign w_exp_bytes = {5'd0, r_nreg, 3'd0} + 16'd4;
    assign w_commit    = rec_pkt_done && (w_state == S_END) && (rec_byte_num == w_exp_bytes);

    always_ff @(posedge eth_rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= S_HDR;
            r_ch       <= '0;
            r_nreg     <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_sh_wave  <= '0;
            r_sh_amp   <= '0;
            r_sh_freq  <= '0;
            r_sh_min   <= '0;
            r_sh_phase <= '0;
            cfg_update <= '0;
            pkt_err    <= 1'b0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                wave_select[4*n +: 4]  <= RST_WAVE;
                amp_ctl[9*n +: 9]      <= RST_AMP;
                freq_ctl[32*n +: 32]   <= RST_FREQ;
                min_ctl[32*n +: 32]    <= RST_MIN;
                phase_ctl[12*n +: 12]  <= RST_PHASE;
            end
`ifdef CFG_STATUS_EN
            pkt_ok_cnt  <= '0;
            pkt_err_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_ch       <= w_ch;
            r_nreg     <= w_nreg;
            r_cnt      <= w_cnt;
            r_addr     <= w_addr;
            r_sh_wave  <= w_sh_wave;
            r_sh_amp   <= w_sh_amp;
            r_sh_freq  <= w_sh_freq;
            r_sh_min   <= w_sh_min;
            r_sh_phase <= w_sh_phase;
            cfg_update <= '0;
            pkt_err    <= 1'b0;
            if (rec_pkt_done) begin
                r_state <= S_HDR;
                if (w_commit) begin
                    for (int unsigned n = 0; n < NUM_CH; n++) begin
                        if (r_ch == CH_W'(n)) begin
                            wave_select[4*n +: 4]  <= w_sh_wave;
                            amp_ctl[9*n +: 9]      <= w_sh_amp;
                            freq_ctl[32*n +: 32]   <= w_sh_freq;
                            min_ctl[32*n +: 32]    <= w_sh_min;
                            phase_ctl[12*n +: 12]  <= w_sh_phase;
                            cfg_update[n]          <= 1'b1;
                        end
                    end
`ifdef CFG_STATUS_EN
                    if (pkt_ok_cnt != 16'hFFFF) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
`endif
                end else begin
                    pkt_err <= 1'b1;
`ifdef CFG_STATUS_EN
                    if (pkt_err_cnt != 16'hFFFF) pkt_err_cnt <= pkt_err_cnt + 16'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_dds_cfg_mc.sv
// Randomised packet bench for eth_dds_cfg_mc against a packet-level reference model.
module tb_eth_dds_cfg_mc;

    localparam int NCH = 2;

    logic                eth_rx_clk = 1'b0;
    logic                sys_rst;
    logic                rec_en;
    logic [31:0]         rec_data;
    logic                rec_pkt_done;
    logic [15:0]         rec_byte_num;
    logic [4*NCH-1:0]    wave_select;
    logic [9*NCH-1:0]    amp_ctl;
    logic [32*NCH-1:0]   freq_ctl;
    logic [32*NCH-1:0]   min_ctl;
    logic [12*NCH-1:0]   phase_ctl;
    logic [NCH-1:0]      cfg_update;
    logic                pkt_err;
`ifdef CFG_STATUS_EN
    logic [15:0]         pkt_ok_cnt;
    logic [15:0]         pkt_err_cnt;
`endif

    eth_dds_cfg_mc #(.NUM_CH(NCH), .MAGIC(16'h5AA5)) dut (
        .eth_rx_clk   (eth_rx_clk),
        .sys_rst      (sys_rst),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .wave_select  (wave_select),
        .amp_ctl      (amp_ctl),
        .freq_ctl     (freq_ctl),
        .min_ctl      (min_ctl),
        .phase_ctl    (phase_ctl),
        .cfg_update   (cfg_update),
`ifdef CFG_STATUS_EN
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_err_cnt  (pkt_err_cnt),
`endif
        .pkt_err      (pkt_err)
    );

    always #4 eth_rx_clk = ~eth_rx_clk;

    // Reference state: active registers per channel and expected pulses
    logic [3:0]     m_wave  [NCH];
    logic [8:0]     m_amp   [NCH];
    logic [31:0]    m_freq  [NCH];
    logic [31:0]    m_min   [NCH];
    logic [11:0]    m_phase [NCH];
    logic [NCH-1:0] exp_upd;
    logic           exp_err;
    int             m_ok;
    int             m_errc;
    bit             chk = 0;

    // Outcome of the last finished packet, applied on the edge that samples rec_pkt_done
    bit             pend;
    bit             pend_ok;
    int             pend_ch;
    logic [3:0]     p_wave;
    logic [8:0]     p_amp;
    logic [31:0]    p_freq;
    logic [31:0]    p_min;
    logic [11:0]    p_phase;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_wave[n]  = 4'd0;
            m_amp[n]   = 9'd256;
            m_freq[n]  = 32'd3615292;
            m_min[n]   = 32'd0;
            m_phase[n] = 12'd1024;
        end
        exp_upd = '0;
        exp_err = 1'b0;
        pend    = 0;
        m_ok    = 0;
        m_errc  = 0;
    endtask

    always @(negedge eth_rx_clk) begin
        if (chk) begin
            n_vec++;
            for (int n = 0; n < NCH; n++) begin
                if (wave_select[4*n +: 4] !== m_wave[n]) begin
                    n_err++;
                    $display("FAIL wave_select ch%0d: got %h want %h", n, wave_select[4*n +: 4], m_wave[n]);
                end
                if (amp_ctl[9*n +: 9] !== m_amp[n]) begin
                    n_err++;
                    $display("FAIL amp_ctl ch%0d: got %h want %h", n, amp_ctl[9*n +: 9], m_amp[n]);
                end
                if (freq_ctl[32*n +: 32] !== m_freq[n]) begin
                    n_err++;
                    $display("FAIL freq_ctl ch%0d: got %h want %h", n, freq_ctl[32*n +: 32], m_freq[n]);
                end
                if (min_ctl[32*n +: 32] !== m_min[n]) begin
                    n_err++;
                    $display("FAIL min_ctl ch%0d: got %h want %h", n, min_ctl[32*n +: 32], m_min[n]);
                end
                if (phase_ctl[12*n +: 12] !== m_phase[n]) begin
                    n_err++;
                    $display("FAIL phase_ctl ch%0d: got %h want %h", n, phase_ctl[12*n +: 12], m_phase[n]);
                end
            end
            if (cfg_update !== exp_upd) begin
                n_err++;
                $display("FAIL cfg_update: got %b want %b", cfg_update, exp_upd);
            end
            if (pkt_err !== exp_err) begin
                n_err++;
                $display("FAIL pkt_err: got %b want %b", pkt_err, exp_err);
            end
`ifdef CFG_STATUS_EN
            if (pkt_ok_cnt !== 16'(m_ok) || pkt_err_cnt !== 16'(m_errc)) begin
                n_err++;
                $display("FAIL status counters: got %0d/%0d want %0d/%0d", pkt_ok_cnt, pkt_err_cnt, m_ok, m_errc);
            end
`endif
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One clock: retire the pending packet outcome into the model, then present inputs
    task automatic drive(input logic en, input logic [31:0] d, input logic done, input logic [15:0] bn);
        @(posedge eth_rx_clk);
        #1;
        exp_upd = '0;
        exp_err = 1'b0;
        if (pend) begin
            pend = 0;
            if (pend_ok) begin
                m_wave[pend_ch]  = p_wave;
                m_amp[pend_ch]   = p_amp;
                m_freq[pend_ch]  = p_freq;
                m_min[pend_ch]   = p_min;
                m_phase[pend_ch] = p_phase;
                exp_upd[pend_ch] = 1'b1;
                if (m_ok != 65535) m_ok++;
            end else begin
                exp_err = 1'b1;
                if (m_errc != 65535) m_errc++;
            end
        end
        rec_en       = en;
        rec_data     = d;
        rec_pkt_done = done;
        rec_byte_num = bn;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 16'd0);
    endtask

    // Decide a whole packet's fate from its word list
    task automatic judge(input logic [31:0] w[$], input logic [15:0] bn);
        int unsigned ch;
        int unsigned nreg;
        logic [31:0] hdr;
        logic [31:0] aw;
        bit ok;
        pend    = 1;
        pend_ok = 0;
        if (w.size() == 0) return;
        hdr  = w[0];
        ch   = 32'(hdr[15:8]);
        nreg = 32'(hdr[7:0]);
        ok = (hdr[31:16] == 16'h5AA5) && (ch < NCH) && (nreg != 0)
             && (w.size() == 1 + 2 * nreg) && (32'(bn) == 4 + 8 * nreg);
        if (!ok) return;
        p_wave  = m_wave[ch];
        p_amp   = m_amp[ch];
        p_freq  = m_freq[ch];
        p_min   = m_min[ch];
        p_phase = m_phase[ch];
        for (int i = 0; i < int'(nreg); i++) begin
            aw = w[1 + 2 * i];
            case (aw[3:0])
                4'd0: p_wave  = w[2 + 2 * i][3:0];
                4'd1: p_amp   = w[2 + 2 * i][8:0];
                4'd2: p_freq  = w[2 + 2 * i];
                4'd3: p_min   = w[2 + 2 * i];
                4'd4: p_phase = w[2 + 2 * i][11:0];
                default: ok = 0;
            endcase
        end
        pend_ok = ok;
        pend_ch = int'(ch);
    endtask

    task automatic send_pkt(input logic [31:0] w[$], input logic [15:0] bn, input bit coinc, input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            drive(1'b1, w[i], (coinc && i == w.size() - 1) ? 1'b1 : 1'b0, bn);
        end
        if (!(coinc && w.size() > 0)) begin
            if (gaps && $urandom_range(0, 1) == 0) idle();
            drive(1'b0, 32'd0, 1'b1, bn);
        end
        judge(w, bn);
    endtask

    task automatic pulse_reset();
        @(posedge eth_rx_clk);
        #1;
        sys_rst      = 1'b1;
        rec_en       = 1'b0;
        rec_pkt_done = 1'b0;
        model_reset();
        @(posedge eth_rx_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic rand_pkt();
        logic [31:0] q[$];
        logic [31:0] hdr;
        logic [31:0] aw;
        logic [15:0] bn;
        int kind;
        int ch;
        int nreg;
        int idx;
        kind = int'($urandom_range(0, 11));
        ch   = int'($urandom_range(0, NCH - 1));
        nreg = int'($urandom_range(1, 4));
        bn   = 16'(4 + 8 * nreg);
        hdr  = {16'h5AA5, 8'(ch), 8'(nreg)};
        if (kind == 1) hdr[31:16] = 16'h1234;
        if (kind == 2) hdr[15:8] = 8'(NCH + int'($urandom_range(0, 5)));
        if (kind == 3) hdr[7:0] = 8'd0;
        q.push_back(hdr);
        for (int i = 0; i < nreg; i++) begin
            q.push_back(($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 4)));
            q.push_back($urandom);
        end
        if (kind == 4) begin
            idx = 1 + 2 * int'($urandom_range(0, nreg - 1));
            aw  = q[idx];
            q[idx] = (aw & 32'hFFFF_FFF0) | 32'($urandom_range(5, 15));
        end
        if (kind == 5) void'(q.pop_back());
        if (kind == 6) q.push_back($urandom);
        if (kind == 7) bn = bn + 16'd8;
        send_pkt(q, bn, $urandom_range(0, 1) == 1, 1'b1);
        if ($urandom_range(0, 2) == 0) idle();
    endtask

    initial begin
        logic [31:0] q[$];
        sys_rst      = 1'b1;
        rec_en       = 1'b0;
        rec_data     = 32'd0;
        rec_pkt_done = 1'b0;
        rec_byte_num = 16'd0;
        model_reset();
        chk = 1;
        repeat (3) @(posedge eth_rx_clk);
        #1;
        sys_rst = 1'b0;
        repeat (2) idle();

        // Reset values
        check_lit("rst amp_ctl", 32'(amp_ctl), {14'd0, 9'd256, 9'd256});
        check_lit("rst freq_ctl ch0", freq_ctl[31:0], 32'd3615292);
        check_lit("rst phase_ctl", 32'(phase_ctl), {8'd0, 12'd1024, 12'd1024});
        check_lit("rst wave/min", 32'(wave_select) | min_ctl[31:0], 32'd0);

        // Two writes to channel 1
        q = '{32'h5AA5_0102, 32'd2, 32'h0010_0000, 32'd4, 32'h0000_0200};
        send_pkt(q, 16'd20, 1'b0, 1'b0);
        idle();
        check_lit("ch1 cfg_update", 32'(cfg_update), 32'h2);
        check_lit("ch1 freq_ctl", freq_ctl[63:32], 32'h0010_0000);
        check_lit("ch1 phase_ctl", 32'(phase_ctl[23:12]), 32'h200);
        check_lit("ch0 freq untouched", freq_ctl[31:0], 32'd3615292);
        idle();
        check_lit("cfg_update one cycle", 32'(cfg_update), 32'h0);

        // Bad tag, then channel out of range
        q = '{32'h1234_0001, 32'd2, 32'h55};
        send_pkt(q, 16'd12, 1'b0, 1'b0);
        idle();
        check_lit("bad tag pkt_err", 32'(pkt_err), 32'h1);
        q = '{32'h5AA5_0201, 32'd2, 32'h55};
        send_pkt(q, 16'd12, 1'b0, 1'b0);
        idle();
        check_lit("bad ch pkt_err", 32'(pkt_err), 32'h1);
        check_lit("bad ch no update", 32'(cfg_update), 32'h0);

        // Byte-count mismatch, then the same packet with the right count
        q = '{32'h5AA5_0001, 32'd0, 32'h3};
        send_pkt(q, 16'd16, 1'b0, 1'b0);
        idle();
        check_lit("bytes mismatch pkt_err", 32'(pkt_err), 32'h1);
        send_pkt(q, 16'd12, 1'b0, 1'b0);
        idle();
        check_lit("retry commit", 32'(cfg_update), 32'h1);
        check_lit("retry wave", 32'(wave_select[3:0]), 32'h3);

        // Last data word coincident with end-of-packet; repeated address keeps last value
        q = '{32'h5AA5_0002, 32'd1, 32'h1FF, 32'h0000_0011, 32'h0AB};
        send_pkt(q, 16'd20, 1'b1, 1'b0);
        idle();
        check_lit("coincident commit", 32'(cfg_update), 32'h1);
        check_lit("repeat addr amp", 32'(amp_ctl[8:0]), 32'h0AB);

        // Reset between address and data word, then a valid packet
        drive(1'b1, 32'h5AA5_0001, 1'b0, 16'd0);
        drive(1'b1, 32'h0000_0002, 1'b0, 16'd0);
        pulse_reset();
        q = '{32'h5AA5_0001, 32'd3, 32'h0000_0777};
        send_pkt(q, 16'd12, 1'b0, 1'b0);
        idle();
        check_lit("post-reset commit", 32'(cfg_update), 32'h1);
        check_lit("post-reset min_ctl", min_ctl[31:0], 32'h777);
`ifdef CFG_STATUS_EN
        check_lit("pkt_ok_cnt", 32'(pkt_ok_cnt), 32'd1);
        check_lit("pkt_err_cnt", 32'(pkt_err_cnt), 32'd0);
`endif

        // Randomised packets, valid and corrupted, with idle gaps
        for (int k = 0; k < 400; k++) rand_pkt();
        // Words with no header sync, then an end strobe
        drive(1'b1, $urandom, 1'b0, 16'd0);
        drive(1'b0, 32'd0, 1'b1, 16'd4);
        pend = 1;
        pend_ok = 0;
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
